// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 transmitter state encoding, command/response bytes and default timing.
`default_nettype none

package ps2_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_ACKWAIT = 3'd5,
    ST_ERR_TO  = 3'd6,
    ST_NACK    = 3'd7
  } tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  localparam int PS2_INHIBIT_CYCLES_DEF       = 6000;
  localparam int PS2_START_TIMEOUT_CYCLES_DEF = 750000;
  localparam int PS2_XFER_TIMEOUT_CYCLES_DEF  = 100000;
  localparam int PS2_SYNC_STAGES_DEF          = 2;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronises the PS/2 clock and data pins and strobes clock falling edges.
`default_nettype none

module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_raw,
  input  logic dat_raw,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_pipe;
  logic [SYNC_STAGES-1:0] dat_pipe;
  logic                   clk_prev;

  // Idle bus level is high, so the chain resets to 1 to avoid a phantom fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_pipe <= '1;
      dat_pipe <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_pipe <= (clk_pipe << 1) | SYNC_STAGES'(clk_raw);
      dat_pipe <= (dat_pipe << 1) | SYNC_STAGES'(dat_raw);
      clk_prev <= clk_sync;
    end
  end

  assign clk_sync = clk_pipe[SYNC_STAGES-1];
  assign dat_sync = dat_pipe[SYNC_STAGES-1];
  assign clk_fall = clk_prev & ~clk_sync;

endmodule

`default_nettype wire

// File: rtl/ps2_command_tx.sv
// ps2_command_tx: PS/2 host-to-device command transmitter with ACK check and timeouts.
// Optional PS2_TX_NACK_RETRY_EN: the first NACK of a command triggers one retransmit.
`default_nettype none

module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = PS2_INHIBIT_CYCLES_DEF,
  parameter int START_TIMEOUT_CYCLES = PS2_START_TIMEOUT_CYCLES_DEF,
  parameter int XFER_TIMEOUT_CYCLES  = PS2_XFER_TIMEOUT_CYCLES_DEF,
  parameter int SYNC_STAGES          = PS2_SYNC_STAGES_DEF
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic       error_nack
);

  localparam int TIMER_W = $clog2(INHIBIT_CYCLES + START_TIMEOUT_CYCLES + XFER_TIMEOUT_CYCLES + 2);
  localparam logic [TIMER_W-1:0] INHIBIT_END = TIMER_W'(INHIBIT_CYCLES);
  localparam logic [TIMER_W-1:0] START_LAST  = TIMER_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST   = TIMER_W'(XFER_TIMEOUT_CYCLES - 1);

  tx_state_t          state, state_n;
  logic [8:0]         shreg, shreg_n;
  logic [3:0]         bitcnt, bitcnt_n;
  logic [TIMER_W-1:0] timer, timer_n, timer_inc;
  logic               clk_oe_n, dat_oe_n, busy_n, sent_n, to_n, nack_n;
  logic               timeout_hit, nack_hit, xfer_expired;
  logic               clk_s, dat_s, fall;
`ifdef PS2_TX_NACK_RETRY_EN
  logic [7:0]         cmd_q, cmd_q_n;
  logic               retried, retried_n;
`endif

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (CLK),
    .rst      (reset),
    .clk_raw  (ps2_clk_in),
    .dat_raw  (ps2_dat_in),
    .clk_sync (clk_s),
    .dat_sync (dat_s),
    .clk_fall (fall)
  );

  assign timer_inc    = (timer == '1) ? timer : timer + 1'b1;
  assign xfer_expired = (timer >= XFER_LAST);

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bitcnt_n    = bitcnt;
    timer_n     = timer_inc;
    clk_oe_n    = ps2_clk_oe;
    dat_oe_n    = ps2_dat_oe;
    busy_n      = busy;
    sent_n      = 1'b0;
    to_n        = 1'b0;
    nack_n      = 1'b0;
    timeout_hit = 1'b0;
    nack_hit    = 1'b0;
`ifdef PS2_TX_NACK_RETRY_EN
    cmd_q_n     = cmd_q;
    retried_n   = retried;
`endif
    case (state)
      ST_IDLE: begin
        timer_n = '0;
        if (send_command) begin
          shreg_n  = {odd_parity(the_command), the_command};
          state_n  = ST_INHIBIT;
          busy_n   = 1'b1;
          clk_oe_n = 1'b1;
          dat_oe_n = 1'b0;
`ifdef PS2_TX_NACK_RETRY_EN
          cmd_q_n   = the_command;
          retried_n = 1'b0;
`endif
        end
      end
      // Data goes low one cycle before the clock is released.
      ST_INHIBIT: begin
        if (timer >= INHIBIT_END) begin
          clk_oe_n = 1'b0;
          timer_n  = '0;
          state_n  = ST_REQ;
        end else if (timer == INHIBIT_END - 1'b1) begin
          dat_oe_n = 1'b1;
        end
      end
      ST_REQ: begin
        if (timer >= START_LAST) begin
          timeout_hit = 1'b1;
        end else if (fall) begin
          dat_oe_n = ~shreg[0];
          shreg_n  = {1'b0, shreg[8:1]};
          bitcnt_n = 4'd1;
          timer_n  = '0;
          state_n  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer_expired) begin
          timeout_hit = 1'b1;
        end else if (fall) begin
          if (bitcnt == 4'd9) begin
            dat_oe_n = 1'b0;
            state_n  = ST_ACK;
          end else begin
            dat_oe_n = ~shreg[0];
            shreg_n  = {1'b0, shreg[8:1]};
            bitcnt_n = bitcnt + 4'd1;
          end
        end
      end
      ST_ACK: begin
        if (xfer_expired) begin
          timeout_hit = 1'b1;
        end else if (fall) begin
          if (!dat_s) begin
            state_n = ST_ACKWAIT;
          end else begin
`ifdef PS2_TX_NACK_RETRY_EN
            if (!retried) begin
              retried_n = 1'b1;
              shreg_n   = {odd_parity(cmd_q), cmd_q};
              clk_oe_n  = 1'b1;
              dat_oe_n  = 1'b0;
              timer_n   = '0;
              state_n   = ST_INHIBIT;
            end else begin
              nack_hit = 1'b1;
            end
`else
            nack_hit = 1'b1;
`endif
          end
        end
      end
      ST_ACKWAIT: begin
        if (xfer_expired) begin
          timeout_hit = 1'b1;
        end else if (clk_s && dat_s) begin
          sent_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      ST_ERR_TO, ST_NACK: state_n = ST_IDLE;
      default:            state_n = ST_IDLE;
    endcase

    if (timeout_hit) begin
      to_n     = 1'b1;
      busy_n   = 1'b0;
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      state_n  = ST_ERR_TO;
    end
    if (nack_hit) begin
      nack_n   = 1'b1;
      busy_n   = 1'b0;
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      state_n  = ST_NACK;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state                         <= ST_IDLE;
      shreg                         <= '0;
      bitcnt                        <= '0;
      timer                         <= '0;
      ps2_clk_oe                    <= 1'b0;
      ps2_dat_oe                    <= 1'b0;
      busy                          <= 1'b0;
      command_was_sent              <= 1'b0;
      error_communication_timed_out <= 1'b0;
      error_nack                    <= 1'b0;
`ifdef PS2_TX_NACK_RETRY_EN
      cmd_q                         <= '0;
      retried                       <= 1'b0;
`endif
    end else begin
      state                         <= state_n;
      shreg                         <= shreg_n;
      bitcnt                        <= bitcnt_n;
      timer                         <= timer_n;
      ps2_clk_oe                    <= clk_oe_n;
      ps2_dat_oe                    <= dat_oe_n;
      busy                          <= busy_n;
      command_was_sent              <= sent_n;
      error_communication_timed_out <= to_n;
      error_nack                    <= nack_n;
`ifdef PS2_TX_NACK_RETRY_EN
      cmd_q                         <= cmd_q_n;
      retried                       <= retried_n;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_command_tx.sv
// tb_ps2_command_tx: directed bench with an open-drain PS/2 device model.
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_command_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int STO  = 400;
  localparam int XTO  = 2000;
  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] the_command = 8'h00;
  logic       send_command = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy;
  logic       command_was_sent, error_communication_timed_out, error_nack;

  ps2_command_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (STO),
    .XFER_TIMEOUT_CYCLES  (XTO),
    .SYNC_STAGES          (SYNC)
  ) dut (
    .CLK                           (CLK),
    .reset                         (reset),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .ps2_clk_in                    (ps2_clk_in),
    .ps2_dat_in                    (ps2_dat_in),
    .ps2_clk_oe                    (ps2_clk_oe),
    .ps2_dat_oe                    (ps2_dat_oe),
    .busy                          (busy),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .error_nack                    (error_nack)
  );

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 CLK = ~CLK;

  int cyc = 0;
  int n_sent = 0, n_to = 0, n_nack = 0;
  int tests = 0, fails = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (command_was_sent)              n_sent <= n_sent + 1;
    if (error_communication_timed_out) n_to   <= n_to + 1;
    if (error_nack)                    n_nack <= n_nack + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 1ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] cmd, output int t_acc);
    @(negedge CLK);
    the_command  = cmd;
    send_command = 1'b1;
    @(negedge CLK);
    send_command = 1'b0;
    t_acc = cyc;
    check("busy_after_accept", 32'(busy), 1);
    check("clk_inhibit_after_accept", 32'(ps2_clk_oe), 1);
  endtask

  // Frame capture: fr[0] start bit, fr[1..8] d0..d7, fr[9] parity, fr[10] stop.
  task automatic device_frame(input int nfalls, input logic ack_val,
                              output logic [10:0] fr, output int t_fall1);
    int w;
    fr      = '0;
    t_fall1 = 0;
    w       = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 300) begin
      @(negedge CLK);
      w++;
    end
    check("request_seen", 32'(w < 300), 1);
    if (w >= 300) return;
    fr[0] = ps2_dat_in;
    for (int i = 1; i <= nfalls; i++) begin
      repeat (HALF) @(negedge CLK);
      dev_clk = 1'b0;
      if (i == 1) t_fall1 = cyc;
      repeat (HALF) @(negedge CLK);
      dev_clk = 1'b1;
      if (i <= 10) fr[i] = ps2_dat_in;
      if (i == 10) dev_dat = ack_val;
      if (i == 11) dev_dat = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy && w < 300) begin
      @(negedge CLK);
      w++;
    end
    check(name, 32'(busy), 0);
    repeat (2) @(negedge CLK);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [10:0] frame;   // {stop, parity, d7..d0, start}
  } vec_t;

  vec_t        vecs [6];
  logic [10:0] fr;
  int          t_acc, t_f1, s0, e0, w;

  initial begin
    vecs[0] = '{8'hED, 11'b1_1_11101101_0};
    vecs[1] = '{8'h00, 11'b1_1_00000000_0};
    vecs[2] = '{8'h01, 11'b1_0_00000001_0};
    vecs[3] = '{8'hF4, 11'b1_0_11110100_0};
    vecs[4] = '{8'hFF, 11'b1_1_11111111_0};
    vecs[5] = '{8'hA5, 11'b1_1_10100101_0};

    repeat (3) @(negedge CLK);
    check("reset_clk_oe", 32'(ps2_clk_oe), 0);
    check("reset_dat_oe", 32'(ps2_dat_oe), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_pulses", {command_was_sent, error_communication_timed_out, error_nack}, 0);
    reset = 1'b0;
    repeat (3) @(negedge CLK);

    // Normal frames with ACK
    for (int i = 0; i < 6; i++) begin
      s0 = n_sent;
      e0 = n_to + n_nack;
      send(vecs[i].cmd, t_acc);
      device_frame(11, 1'b0, fr, t_f1);
      check($sformatf("frame_%02h", vecs[i].cmd), 32'(fr), 32'(vecs[i].frame));
      wait_idle("idle_after_frame");
      check("sent_pulse_count", n_sent - s0, 1);
      check("no_error_pulse", (n_to + n_nack) - e0, 0);
      check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
    end

    // Device never clocks: start timeout
    e0 = n_to;
    send(PS2_CMD_ENABLE, t_acc);
    w = 0;
    while (!error_communication_timed_out && w < 1000) begin
      @(negedge CLK);
      w++;
    end
    check("start_timeout_latency", cyc - t_acc, INH + 1 + STO);
    check("start_timeout_lines_busy", {ps2_clk_oe, ps2_dat_oe, busy}, 0);
    wait_idle("idle_after_start_to");
    check("start_timeout_count", n_to - e0, 1);

    // Device stops after 5 falls: transfer timeout, measured from the pin edge
    s0 = n_sent;
    e0 = n_to;
    send(PS2_CMD_SET_LEDS, t_acc);
    device_frame(5, 1'b0, fr, t_f1);
    w = 0;
    while (!error_communication_timed_out && w < 3000) begin
      @(negedge CLK);
      w++;
    end
    // Internal fall strobe lags the pin by SYNC stages plus the edge detector.
    check("xfer_timeout_latency", cyc - t_f1, XTO + SYNC + 1);
    wait_idle("idle_after_xfer_to");
    check("xfer_timeout_count", n_to - e0, 1);
    check("xfer_timeout_no_sent", n_sent - s0, 0);

    // NACK at the ACK slot
    s0 = n_sent;
    e0 = n_nack;
    send(8'h01, t_acc);
    device_frame(11, 1'b1, fr, t_f1);
    check("nack_frame", 32'(fr), 32'(11'b1_0_00000001_0));
`ifdef PS2_TX_NACK_RETRY_EN
    device_frame(11, 1'b0, fr, t_f1);
    check("retry_frame", 32'(fr), 32'(11'b1_0_00000001_0));
    wait_idle("idle_after_retry");
    check("retry_sent", n_sent - s0, 1);
    check("retry_no_nack", n_nack - e0, 0);
`else
    wait_idle("idle_after_nack");
    check("nack_count", n_nack - e0, 1);
    check("nack_no_sent", n_sent - s0, 0);
`endif

    // Reset during fall 6 of an all-zero byte (host is holding data low)
    send(8'h00, t_acc);
    w = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 300) begin
      @(negedge CLK);
      w++;
    end
    for (int i = 1; i <= 5; i++) begin
      repeat (HALF) @(negedge CLK);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLK);
      dev_clk = 1'b1;
    end
    repeat (HALF) @(negedge CLK);
    dev_clk = 1'b0;
    repeat (3) @(negedge CLK);
    check("before_reset_busy_dat", {busy, ps2_dat_oe}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("async_reset_midframe", {ps2_clk_oe, ps2_dat_oe, busy}, 0);
    @(negedge CLK);
    reset   = 1'b0;
    dev_clk = 1'b1;
    repeat (4) @(negedge CLK);

    // Clean frame after reset; a second request while busy is dropped
    s0 = n_sent;
    send(PS2_CMD_ENABLE, t_acc);
    @(negedge CLK);
    the_command  = 8'h55;
    send_command = 1'b1;
    @(negedge CLK);
    send_command = 1'b0;
    device_frame(11, 1'b0, fr, t_f1);
    check("frame_after_reset", 32'(fr), 32'(11'b1_0_11110100_0));
    wait_idle("idle_after_reset_frame");
    check("single_sent_when_busy_req", n_sent - s0, 1);
    repeat (40) @(negedge CLK);
    check("no_queued_command", {ps2_clk_oe, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
